// File: rtl/mem_bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arb_pkg
// Purpose  : Shared FSM encoding and default sizes for mem_bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int c_DEF_NREQ    = 3;
    localparam int c_DEF_ADDR_W  = 16;
    localparam int c_DEF_DATA_W  = 16;
    localparam int c_DEF_TIMEOUT = 255;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker; searches from last+1 mod NREQ.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import mem_bus_arb_pkg::*;
#(
    parameter int NREQ = c_DEF_NREQ,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            valid,
    output logic [IW-1:0]   winner
);

    logic [IW:0] w_pos;

    // Scan farthest candidate first so the nearest requester after last wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        w_pos  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_pos = {1'b0, last} + (IW+1)'(k);
            if (w_pos >= (IW+1)'(NREQ)) begin
                w_pos = w_pos - (IW+1)'(NREQ);
            end
            if (req[w_pos[IW-1:0]]) begin
                valid  = 1'b1;
                winner = w_pos[IW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Round-robin owner of a shared 1-cycle-latency memory bus.
//            Optional grant timeout enabled by defining ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
    import mem_bus_arb_pkg::*;
#(
    parameter int NREQ    = c_DEF_NREQ,
    parameter int ADDR_W  = c_DEF_ADDR_W,
    parameter int DATA_W  = c_DEF_DATA_W,
    parameter int TIMEOUT = c_DEF_TIMEOUT
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [NREQ-1:0]        REQ,
    input  logic [NREQ-1:0]        REL,
    output logic [NREQ-1:0]        GNT,
    input  logic [NREQ-1:0]        M_EN,
    input  logic [NREQ-1:0]        M_WE,
    input  logic [NREQ*ADDR_W-1:0] M_ADDR,
    input  logic [NREQ*DATA_W-1:0] M_WDATA,
    output logic [DATA_W-1:0]      M_RDATA,
    output logic [NREQ-1:0]        M_RVALID,
    output logic                   BUS_EN,
    output logic                   BUS_WE,
    output logic [ADDR_W-1:0]      BUS_ADDR,
    output logic [DATA_W-1:0]      BUS_WDATA,
    input  logic [DATA_W-1:0]      BUS_RDATA,
    output logic                   TIMEOUT_ERR
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      r_state, w_state_nxt;
    logic [IW-1:0]   r_owner, w_owner_nxt;
    logic [IW-1:0]   r_last, w_last_nxt;
    logic            w_pick_valid;
    logic [IW-1:0]   w_pick_idx;
    logic            w_release;
    logic            w_timeout;
    logic            w_force;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_rvalid;
    logic            r_timeout_err;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req    (REQ),
        .last   (r_last),
        .valid  (w_pick_valid),
        .winner (w_pick_idx)
    );

    assign w_release = REL[r_owner] | ~REQ[r_owner];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_to_cnt;

    // Held at zero outside GRANT, so it starts from zero on every new grant.
    always_ff @(posedge CLK) begin
        if (RESET || (r_state != GRANT)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end
    end

    assign w_timeout = (r_state == GRANT) && (r_to_cnt == 8'(TIMEOUT - 1));
`else
    // Grants never expire in this build; TIMEOUT has no effect.
    assign w_timeout = (TIMEOUT < 0);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_force     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = GRANT;
                    w_owner_nxt = w_pick_idx;
                    w_last_nxt  = w_pick_idx;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_state_nxt = DRAIN;
                end else if (w_timeout) begin
                    w_state_nxt = DRAIN;
                    w_force     = 1'b1;
                end
            end
            DRAIN:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= IDLE;
            r_owner       <= '0;
            r_last        <= IW'(NREQ - 1);
            r_gnt         <= '0;
            r_rvalid      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_owner       <= w_owner_nxt;
            r_last        <= w_last_nxt;
            r_gnt         <= (w_state_nxt == GRANT) ? (NREQ'(1) << w_owner_nxt) : '0;
            r_rvalid      <= (BUS_EN && !BUS_WE) ? (NREQ'(1) << r_owner) : '0;
            r_timeout_err <= w_force;
        end
    end

    // Owner's access goes straight to the bus so it costs no extra cycle.
    always_comb begin
        BUS_EN    = 1'b0;
        BUS_WE    = 1'b0;
        BUS_ADDR  = '0;
        BUS_WDATA = '0;
        if (r_state == GRANT) begin
            BUS_EN    = M_EN[r_owner];
            BUS_WE    = M_WE[r_owner];
            BUS_ADDR  = M_ADDR[int'(r_owner) * ADDR_W +: ADDR_W];
            BUS_WDATA = M_WDATA[int'(r_owner) * DATA_W +: DATA_W];
        end
    end

    assign GNT         = r_gnt;
    assign M_RVALID    = r_rvalid;
    assign M_RDATA     = BUS_RDATA;
    assign TIMEOUT_ERR = r_timeout_err;

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Round-robin arbiter that shares one synchronous single-port memory bus among up to NREQ requesters, e.g. the frame-copy sequencer, the keyboard controller's mailbox and a CPU port. It owns bus ownership: it grants the bus to one requester at a time and muxes that requester's enable, write, address and data onto the shared bus. It also steers 1-cycle-latency read data back to the owner. It sits between the requesters and the RAM/VRAM/KRAM port.

## Interface
Parameters:
- NREQ, 3, number of requesters (2..8)
- ADDR_W, 16, bus address width
- DATA_W, 16, bus data width
- TIMEOUT, 255, max cycles a grant may be held (used only with the timeout feature)

Ports:
- CLK  in  1  sole clock; all state updates on posedge
- RESET  in  1  synchronous, active-high reset
- REQ  in  NREQ  per-requester bus request, level
- REL  in  NREQ  per-requester release pulse
- GNT  out  NREQ  one-hot grant, registered
- M_EN  in  NREQ  per-requester access enable
- M_WE  in  NREQ  per-requester write enable
- M_ADDR  in  NREQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
- M_WDATA  in  NREQ*DATA_W  flattened write data
- M_RDATA  out  DATA_W  read data, broadcast to all requesters
- M_RVALID  out  NREQ  per-requester read-data-valid, one cycle after its read
- BUS_EN, BUS_WE  out  1  to memory
- BUS_ADDR  out  ADDR_W  to memory
- BUS_WDATA  out  DATA_W  to memory
- BUS_RDATA  in  DATA_W  from memory, valid one cycle after a read
- TIMEOUT_ERR  out  1  one-cycle pulse on a forced release

## Operation
- FSM states: IDLE, GRANT, DRAIN.
- IDLE: if any REQ bit is high, pick the winner round-robin, starting the search at LAST+1 mod NREQ. Load OWNER and LAST with the winner, go to GRANT. Otherwise stay in IDLE.
- GRANT: GNT[OWNER]=1. The bus carries the owner's M_EN/M_WE/M_ADDR/M_WDATA combinationally. All non-owner M_EN are ignored.
- Release: REL[OWNER]=1 or REQ[OWNER]=0 sends the FSM to DRAIN. An access presented in the release cycle is still performed.
- DRAIN: GNT all zero and the bus idle. Always goes to IDLE next.
- Read return: M_RVALID[i] is registered (BUS_EN & ~BUS_WE & OWNER==i). M_RDATA = BUS_RDATA.
- REL/REQ from non-owners are ignored while another requester holds GRANT.
- Outside GRANT: BUS_EN=BUS_WE=0, BUS_ADDR=BUS_WDATA=0.
- RESET (including mid-transaction) forces IDLE, GNT=0, M_RVALID=0, TIMEOUT_ERR=0, and LAST=NREQ-1, so requester 0 wins first. A read in flight at reset produces no RVALID.

## Timing
- REQ sampled in IDLE at edge t gives GNT high from t+1. The owner may access the bus in that same cycle.
- Write: one cycle per access, back-to-back allowed.
- Read: data and M_RVALID arrive one cycle after the access cycle, including after the release cycle (i.e. during DRAIN).
- Release at cycle t: GNT low in t+1 (DRAIN), IDLE at t+2, next GNT at t+3 at the earliest.
- Simultaneous requests are served in rotating order. No requester waits longer than NREQ-1 grants.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entering GRANT and increments each GRANT cycle.
  - When it reaches TIMEOUT, the grant is forcibly released: FSM goes to DRAIN and TIMEOUT_ERR pulses for exactly one cycle, in the cycle GNT drops.
  - An access in the final GRANT cycle is still performed.
- ARB_TIMEOUT_EN undefined: no counter; a grant lasts until release. TIMEOUT_ERR is tied 0 and the port is kept.

## Structure
- Package mem_bus_arb_pkg: FSM state encoding (IDLE/GRANT/DRAIN), default width constants, TIMEOUT default.
- Sub-module rr_pick: combinational round-robin picker. Inputs are the REQ vector and LAST; outputs are a valid flag and the winner index.
- Everything else (FSM, owner mux, RVALID register, timeout counter) lives in mem_bus_arbiter.

## Test plan
- Reset, then REQ=001: GNT=001 one cycle later. Owner writes 0xBEEF to 0x0010 and reads it back. M_RDATA=0xBEEF with M_RVALID[0] one cycle after the read, and M_RVALID[1], M_RVALID[2] stay 0.
- REQ=111 held, each owner releasing after one access: grant order 0,1,2,0. Next GNT follows each release by 3 cycles.
- Non-owner 1 drives M_EN/M_WE/addr 0x0020 while 0 owns the bus: BUS_ADDR shows only the owner's address, memory at 0x0020 unchanged.
- Owner reads in the REL cycle: GNT drops next cycle, and M_RVALID for the owner still fires in DRAIN with the correct data.
- RESET asserted mid-grant with a read pending: next cycle GNT=0, M_RVALID=0, BUS_EN=0. With REQ=110 after reset, requester 1 wins.
- ARB_TIMEOUT_EN, TIMEOUT=4, owner never releases: GNT drops after 4 GRANT cycles and TIMEOUT_ERR pulses once. Without the macro, GNT is held for 1000 cycles and TIMEOUT_ERR stays 0.
